// File: rtl/rtc_adapter_scan_if.sv
// Display-side bus of the stopwatch seven-segment scan driver.
// The master drives the scan clock and digit data; the slave returns the anode, segment and DP lines.
interface rtc_adapter_scan_if #(
    parameter int NUM_DIGITS = 8
);
    logic                    i_intclk;
    logic [4*NUM_DIGITS-1:0] i_digits;
    logic [NUM_DIGITS-1:0]   i_dp;
    logic [NUM_DIGITS-1:0]   o_an;
    logic [6:0]              o_seg;
    logic                    o_dp;

    modport master (
        output i_intclk,
        output i_digits,
        output i_dp,
        input  o_an,
        input  o_seg,
        input  o_dp
    );

    modport slave (
        input  i_intclk,
        input  i_digits,
        input  i_dp,
        output o_an,
        output o_seg,
        output o_dp
    );
endinterface

// File: rtl/rtc_adapter_scan.sv
// Multiplexed seven-segment scan driver with anode dead time and a frame-latched digit snapshot.
// Defining RTC_SCAN_LZB_EN adds leading-zero blanking, which is evaluated on the snapshot.
module rtc_adapter_scan #(
    parameter int NUM_DIGITS  = 8,
    parameter int DEAD_CYCLES = 4
) (
    input  logic               i_sclk,
    input  logic               i_reset,
    rtc_adapter_scan_if.slave  bus
);
    localparam int                  IDX_W     = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [7:0]          DEAD_LOAD = 8'(DEAD_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        DEAD,
        DRIVE
    } state_t;

    state_t                  state_q;
    logic                    intclk_q;
    logic [IDX_W-1:0]        idx_q;
    logic [IDX_W-1:0]        idx_d;
    logic [7:0]              deadCnt_q;
    logic [4*NUM_DIGITS-1:0] frameDigits_q;
    logic [4*NUM_DIGITS-1:0] frameDigits_d;
    logic [NUM_DIGITS-1:0]   frameDp_q;
    logic [NUM_DIGITS-1:0]   frameDp_d;
    logic [NUM_DIGITS-1:0]   anPend_q;
    logic [NUM_DIGITS-1:0]   anPend_d;
    logic [NUM_DIGITS-1:0]   an_q;
    logic [6:0]              seg_q;
    logic                    dp_q;
    logic                    dp_d;
    logic [3:0]              nibble_d;
    logic                    tick;

    function automatic logic [6:0] decodeHex(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'h0:    pattern = 7'b1000000;
            4'h1:    pattern = 7'b1111001;
            4'h2:    pattern = 7'b0100100;
            4'h3:    pattern = 7'b0110000;
            4'h4:    pattern = 7'b0011001;
            4'h5:    pattern = 7'b0010010;
            4'h6:    pattern = 7'b0000010;
            4'h7:    pattern = 7'b1111000;
            4'h8:    pattern = 7'b0000000;
            4'h9:    pattern = 7'b0010000;
            4'hA:    pattern = 7'b0001000;
            4'hB:    pattern = 7'b0000011;
            4'hC:    pattern = 7'b1000110;
            4'hD:    pattern = 7'b0100001;
            4'hE:    pattern = 7'b0000110;
            default: pattern = 7'b0001110;
        endcase
        return pattern;
    endfunction

    // Next digit and its pattern; the digit-0 slot reads the data being latched on this same edge.
    always_comb begin
        tick          = (bus.i_intclk != intclk_q);
        idx_d         = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        frameDigits_d = frameDigits_q;
        frameDp_d     = frameDp_q;
        if (tick && (idx_d == '0)) begin
            frameDigits_d = bus.i_digits;
            frameDp_d     = bus.i_dp;
        end
        nibble_d = frameDigits_d[4*idx_d +: 4];
`ifdef RTC_SCAN_LZB_EN
        if ((idx_d != '0) && ((frameDigits_d >> (4*idx_d)) == '0)) begin
            anPend_d = '1;
            dp_d     = 1'b1;
        end else begin
            anPend_d = ~(NUM_DIGITS'(1) << idx_d);
            dp_d     = ~frameDp_d[idx_d];
        end
`else
        anPend_d = ~(NUM_DIGITS'(1) << idx_d);
        dp_d     = ~frameDp_d[idx_d];
`endif
    end

    always_ff @(posedge i_sclk) begin
        if (i_reset) begin
            intclk_q      <= bus.i_intclk;
            state_q       <= IDLE;
            idx_q         <= LAST_IDX;
            deadCnt_q     <= '0;
            frameDigits_q <= '0;
            frameDp_q     <= '0;
            anPend_q      <= '1;
            an_q          <= '1;
            seg_q         <= 7'b1111111;
            dp_q          <= 1'b1;
        end else begin
            intclk_q      <= bus.i_intclk;
            frameDigits_q <= frameDigits_d;
            frameDp_q     <= frameDp_d;
            if (tick) begin
                idx_q     <= idx_d;
                seg_q     <= decodeHex(nibble_d);
                dp_q      <= dp_d;
                anPend_q  <= anPend_d;
                deadCnt_q <= DEAD_LOAD;
                if (DEAD_CYCLES == 0) begin
                    an_q    <= anPend_d;
                    state_q <= DRIVE;
                end else begin
                    an_q    <= '1;
                    state_q <= DEAD;
                end
            end else begin
                case (state_q)
                    DEAD: begin
                        // The anode turns on at the edge where the count would reach zero.
                        if (deadCnt_q <= 8'd1) begin
                            deadCnt_q <= '0;
                            an_q      <= anPend_q;
                            state_q   <= DRIVE;
                        end else begin
                            deadCnt_q <= deadCnt_q - 8'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.o_an  = an_q;
    assign bus.o_seg = seg_q;
    assign bus.o_dp  = dp_q;
endmodule
